// File: rtl/regfile_multiport.sv
// Register file with NUM_READ combinational read ports and two byte-masked write ports.
// It also provides an optional hardwired zero register, optional same-cycle bypass and a per-register dirty bitmap.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr_i,
  output logic [NUM_READ*DATA_W-1:0]   read_data_o,
  input  logic                         wr0_enable_i,
  input  logic [ADDR_W-1:0]            wr0_addr_i,
  input  logic [DATA_W-1:0]            wr0_data_i,
  input  logic [DATA_W/8-1:0]          wr0_byte_mask_i,
  input  logic                         wr1_enable_i,
  input  logic [ADDR_W-1:0]            wr1_addr_i,
  input  logic [DATA_W-1:0]            wr1_data_i,
  input  logic [DATA_W/8-1:0]          wr1_byte_mask_i,
  output logic [2**ADDR_W-1:0]         dirty_o,
  input  logic                         dirty_clear_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  dirty_q, dirty_d, dirty_set;
  logic [BYTES-1:0]  wr0_be, wr1_be;

  // Effective byte enables: a write to the hardwired zero register is dropped here,
  // so it never reaches storage, bypass or the dirty bitmap.
  always_comb begin
    wr0_be = wr0_enable_i ? wr0_byte_mask_i : '0;
    wr1_be = wr1_enable_i ? wr1_byte_mask_i : '0;
    if (ZERO_REG != 0 && wr0_addr_i == '0) wr0_be = '0;
    if (ZERO_REG != 0 && wr1_addr_i == '0) wr1_be = '0;
  end

  // Port 1 is applied after port 0, so it wins on overlapping bytes.
  always_comb begin
    dirty_set = '0;
    for (int r = 0; r < DEPTH; r++) begin
      regs_d[r] = regs_q[r];
      for (int b = 0; b < BYTES; b++) begin
        if (wr0_be[b] && wr0_addr_i == ADDR_W'(r)) regs_d[r][8*b +: 8] = wr0_data_i[8*b +: 8];
        if (wr1_be[b] && wr1_addr_i == ADDR_W'(r)) regs_d[r][8*b +: 8] = wr1_data_i[8*b +: 8];
      end
      dirty_set[r] = ((|wr0_be) && wr0_addr_i == ADDR_W'(r)) ||
                     ((|wr1_be) && wr1_addr_i == ADDR_W'(r));
    end
  end

  always_comb begin
    dirty_d = dirty_set | (dirty_clear_i ? '0 : dirty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      dirty_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= regs_d[r];
      dirty_q <= dirty_d;
    end
  end

  assign dirty_o = dirty_q;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    assign addr = read_addr_i[k*ADDR_W +: ADDR_W];
    always_comb begin
      data = (BYPASS != 0 && !rst_i) ? regs_d[addr] : regs_q[addr];
      if (ZERO_REG != 0 && addr == '0) data = '0;
    end
    assign read_data_o[k*DATA_W +: DATA_W] = data;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench: one 4-read-port instance without bypass and one 2-read-port instance with bypass,
// both driven by the same write, reset and clear stimulus.
module tb_regfile_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] ra_a;
  logic [127:0] rd_a;
  logic [9:0]  ra_b;
  logic [63:0] rd_b;
  logic        wr0_en, wr1_en, dclr;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [3:0]  wr0_mask, wr1_mask;
  logic [31:0] dirty_a, dirty_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_READ(4), .ZERO_REG(1), .BYPASS(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .read_addr_i(ra_a), .read_data_o(rd_a),
    .wr0_enable_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data), .wr0_byte_mask_i(wr0_mask),
    .wr1_enable_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data), .wr1_byte_mask_i(wr1_mask),
    .dirty_o(dirty_a), .dirty_clear_i(dclr));

  regfile_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk_i(clk), .rst_i(rst), .read_addr_i(ra_b), .read_data_o(rd_b),
    .wr0_enable_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data), .wr0_byte_mask_i(wr0_mask),
    .wr1_enable_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data), .wr1_byte_mask_i(wr1_mask),
    .dirty_o(dirty_b), .dirty_clear_i(dclr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 0; wr1_en = 0; dclr = 0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    wr0_mask = '0; wr1_mask = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    wr0_en = 1; wr0_addr = a; wr0_data = d; wr0_mask = m;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    wr1_en = 1; wr1_addr = a; wr1_data = d; wr1_mask = m;
  endtask

  task automatic rda(input int k, input logic [4:0] a);
    ra_a[k*5 +: 5] = a;
  endtask

  task automatic rdb(input int k, input logic [4:0] a);
    ra_b[k*5 +: 5] = a;
  endtask

  initial begin
    rst = 1; ra_a = '0; ra_b = '0;
    idle();
    tick(); tick();
    rda(0, 5'd5); rda(1, 5'd0); #1;
    check("reset_dirty", dirty_a, 32'h0);
    check("reset_reg5", rd_a[31:0], 32'h0);
    check("reset_reg0", rd_a[63:32], 32'h0);
    rst = 0;

    // Full-word fill: each register i gets value i.
    for (int i = 0; i < 32; i++) begin
      wr0(5'(i), 32'(i), 4'hF);
      rda(0, 5'(i - 1)); rda(1, 5'(i)); rdb(1, 5'(i));
      #1;
      check("fill_pre_edge", rd_a[63:32], 32'h0);
      check("fill_bypass", rd_b[63:32], (i == 0) ? 32'h0 : 32'(i));
      if (i > 0) check("fill_prev", rd_a[31:0], (i == 1) ? 32'h0 : 32'(i - 1));
      tick();
      check("fill_post_edge", rd_a[63:32], (i == 0) ? 32'h0 : 32'(i));
    end
    idle();
    rda(0, 5'd31); rda(1, 5'd0); #1;
    check("fill_reg31", rd_a[31:0], 32'h0000001F);
    check("fill_reg0", rd_a[63:32], 32'h0);
    check("fill_dirty", dirty_a, 32'hFFFF_FFFE);

    // Byte mask: set byte 1 of every register.
    for (int i = 0; i < 32; i++) begin
      wr0(5'(i), 32'hFFFF_FFFF, 4'b0010);
      tick();
    end
    idle();
    rda(0, 5'd5); rda(1, 5'd0); rda(2, 5'd31); #1;
    check("mask_reg5", rd_a[31:0], 32'h0000FF05);
    check("mask_reg0", rd_a[63:32], 32'h0);
    check("mask_reg31", rd_a[95:64], 32'h0000FF1F);

    // Dirty: clear, two writes, then clear colliding with a write.
    dclr = 1; tick(); idle();
    check("dirty_cleared", dirty_a, 32'h0);
    wr0(5'd2, 32'h2, 4'hF); wr1(5'd9, 32'h9, 4'hF); tick(); idle();
    check("dirty_2_9", dirty_a, 32'h0000_0204);
    dclr = 1; wr0(5'd4, 32'h4, 4'hF); tick(); idle();
    check("dirty_clear_set", dirty_a, 32'h0000_0010);
    check("dirty_byp_inst", dirty_b, 32'h0000_0010);

    // Reset together with a write to 6; bypass must be suppressed under reset.
    rst = 1; wr0(5'd6, 32'h1234_5678, 4'hF); rdb(1, 5'd6); #1;
    check("rst_no_bypass", rd_b[63:32], 32'h0000FF06);
    tick(); idle();
    rda(0, 5'd6); rda(1, 5'd5); rda(2, 5'd31); #1;
    check("rst_dirty", dirty_a, 32'h0);
    check("rst_reg6", rd_a[31:0], 32'h0);
    check("rst_reg5", rd_a[63:32], 32'h0);
    check("rst_reg31", rd_a[95:64], 32'h0);
    check("rst_byp_reg6", rd_b[63:32], 32'h0);
    rst = 0;

    // Dual-write collision on register 3.
    wr0(5'd3, 32'hAAAA_AAAA, 4'b0011); wr1(5'd3, 32'h5555_5555, 4'b0110);
    rdb(0, 5'd3); rda(0, 5'd3); #1;
    check("coll_bypass", rd_b[31:0], 32'h0055_55AA);
    check("coll_pre_edge", rd_a[31:0], 32'h0);
    tick(); idle(); #1;
    check("coll_reg3", rd_a[31:0], 32'h0055_55AA);

    // Bypass on register 7.
    wr0(5'd7, 32'h1122_3344, 4'hF); tick();
    wr0(5'd7, 32'hDEAD_BEEF, 4'b1001); rdb(1, 5'd7); rda(1, 5'd7); #1;
    check("byp_same_cycle", rd_b[63:32], 32'hDE22_33EF);
    check("nobyp_old", rd_a[63:32], 32'h1122_3344);
    tick(); idle(); #1;
    check("byp_committed", rd_a[63:32], 32'hDE22_33EF);
    check("byp_committed_b", rd_b[63:32], 32'hDE22_33EF);

    // Zero register under bypass, and an enabled write with empty mask.
    dclr = 1; tick(); idle();
    wr0(5'd0, 32'hFFFF_FFFF, 4'hF); wr1(5'd10, 32'hFFFF_FFFF, 4'h0);
    rdb(0, 5'd0); rdb(1, 5'd10); #1;
    check("zero_bypass", rd_b[31:0], 32'h0);
    check("mask0_bypass", rd_b[63:32], 32'h0);
    tick(); idle(); rda(0, 5'd10); #1;
    check("zero_mask0_dirty", dirty_a, 32'h0);
    check("mask0_reg10", rd_a[31:0], 32'h0);

    // Multi-read: distinct then identical addresses.
    wr0(5'd5, 32'h0000_0055, 4'hF); wr1(5'd31, 32'h3100_0031, 4'hF); tick(); idle();
    rda(0, 5'd3); rda(1, 5'd7); rda(2, 5'd5); rda(3, 5'd31); #1;
    check("mr_p0", rd_a[31:0], 32'h0055_55AA);
    check("mr_p1", rd_a[63:32], 32'hDE22_33EF);
    check("mr_p2", rd_a[95:64], 32'h0000_0055);
    check("mr_p3", rd_a[127:96], 32'h3100_0031);
    for (int k = 0; k < 4; k++) rda(k, 5'd7);
    #1;
    for (int k = 0; k < 4; k++) check("mr_same", rd_a[k*32 +: 32], 32'hDE22_33EF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
